// File: rtl/h_sync_timing_detector_if.sv
// Signal bundle between an h_sync source (master) and the h_sync timing detector (slave).
interface h_sync_timing_detector_if #(
    parameter int COUNTER_WIDTH = 11
);
    logic                     h_sync;
    logic [COUNTER_WIDTH-1:0] period_out;
    logic [COUNTER_WIDTH-1:0] width_out;
    logic                     measure_valid;
    logic                     locked;
    logic [COUNTER_WIDTH-1:0] position_out;
    logic                     timeout_err;

    modport master (
        output h_sync,
        input  period_out, width_out, measure_valid, locked, position_out, timeout_err
    );

    modport slave (
        input  h_sync,
        output period_out, width_out, measure_valid, locked, position_out, timeout_err
    );
endinterface

// File: rtl/h_sync_timing_detector.sv
// Measures incoming h_sync line period / pulse width, reports lock, and regenerates a position counter.
// Optional H_SYNC_INPUT_SYNCHRONIZER_EN adds a 2-flop synchronizer in front of the edge detector.
module h_sync_timing_detector #(
    parameter int COUNTER_WIDTH   = 11,
    parameter int EXPECTED_PERIOD = 1328,
    parameter int EXPECTED_WIDTH  = 1072,
    parameter int TOLERANCE       = 2,
    parameter int LOCK_LINES      = 4
) (
    input  logic                    control_clock,
    input  logic                    reset,
    h_sync_timing_detector_if.slave bus
);
    localparam int                W           = COUNTER_WIDTH;
    localparam logic [W-1:0]      CNT_MAX     = '1;
    localparam logic [W-1:0]      CNT_PRE_MAX = CNT_MAX - 1'b1;
    localparam logic signed [W:0] EXP_P       = $signed((W+1)'(EXPECTED_PERIOD));
    localparam logic signed [W:0] EXP_W       = $signed((W+1)'(EXPECTED_WIDTH));
    localparam logic signed [W:0] TOL         = $signed((W+1)'(TOLERANCE));
    localparam logic [3:0]        LOCK_TARGET = 4'(LOCK_LINES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    logic w_h_sync_in;

`ifdef H_SYNC_INPUT_SYNCHRONIZER_EN
    logic [1:0] r_sync;

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[0], bus.h_sync};
    end

    assign w_h_sync_in = r_sync[1];
`else
    assign w_h_sync_in = bus.h_sync;
`endif

    logic         r_s, r_s_d;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_width_lat;
    logic         r_fall_seen;
    logic         r_ref_seen;
    logic         r_meas_pend;
    logic [W-1:0] r_period_pend;
    logic [W-1:0] r_width_pend;
    logic [W-1:0] r_period_out;
    logic [W-1:0] r_width_out;
    logic         r_measure_valid;
    logic         r_timeout_err;
    logic         r_locked;
    logic [3:0]   r_match_cnt;
    state_t       r_state;

    logic         w_rise, w_fall;
    logic         w_at_pre_max;
    logic         w_sat_hit;
    logic [W-1:0] w_cnt_inc;
    logic         w_match;

    // NOTE: the signed difference is built in a local variable with blocking assignment; it is pure combinational scratch, never state.
    function automatic logic within_tol(input logic [W-1:0] meas, input logic signed [W:0] expected);
        logic signed [W:0] diff;
        diff = $signed({1'b0, meas}) - expected;
        return diff[W] ? ((-diff) <= TOL) : (diff <= TOL);
    endfunction

    assign w_rise       = r_s & ~r_s_d;
    assign w_fall       = ~r_s & r_s_d;
    assign w_at_pre_max = (r_cnt == CNT_PRE_MAX);
    assign w_sat_hit    = ~w_rise & w_at_pre_max;
    assign w_cnt_inc    = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
    assign w_match      = within_tol(r_period_pend, EXP_P) & within_tol(r_width_pend, EXP_W);

    // NOTE: every sequential block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            r_s           <= 1'b0;
            r_s_d         <= 1'b0;
            r_cnt         <= '0;
            r_width_lat   <= '0;
            r_fall_seen   <= 1'b0;
            r_ref_seen    <= 1'b0;
            r_meas_pend   <= 1'b0;
            r_period_pend <= '0;
            r_width_pend  <= '0;
        end else begin
            r_s   <= w_h_sync_in;
            r_s_d <= r_s;
            if (w_rise) begin
                // A rise landing on the saturation cycle cannot yield a trustworthy period.
                r_meas_pend   <= r_ref_seen & r_fall_seen & ~w_at_pre_max;
                r_period_pend <= w_cnt_inc;
                r_width_pend  <= r_width_lat;
                r_ref_seen    <= 1'b1;
                r_fall_seen   <= 1'b0;
                r_cnt         <= '0;
            end else begin
                r_meas_pend <= 1'b0;
                r_cnt       <= w_cnt_inc;
                if (w_fall) begin
                    r_width_lat <= w_cnt_inc;
                    r_fall_seen <= 1'b1;
                end
                if (w_sat_hit) begin
                    r_ref_seen  <= 1'b0;
                    r_fall_seen <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            r_period_out    <= '0;
            r_width_out     <= '0;
            r_measure_valid <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_measure_valid <= r_meas_pend;
            r_timeout_err   <= w_sat_hit;
            if (r_meas_pend) begin
                r_period_out <= r_period_pend;
                r_width_out  <= r_width_pend;
            end
        end
    end

    // Lock FSM: timeout beats everything, then re-anchoring rises, then measurement results.
    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
        end else if (w_sat_hit) begin
            r_state     <= SEARCH;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
        end else if (w_rise && (r_state == SEARCH || w_at_pre_max)) begin
            r_state     <= MEASURE;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
        end else if (r_meas_pend) begin
            case (r_state)
                MEASURE: begin
                    if (!w_match) begin
                        r_match_cnt <= '0;
                    end else if (r_match_cnt + 1'b1 >= LOCK_TARGET) begin
                        r_match_cnt <= LOCK_TARGET;
                        r_state     <= LOCKED;
                        r_locked    <= 1'b1;
                    end else begin
                        r_match_cnt <= r_match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_match) begin
                        r_state     <= MEASURE;
                        r_match_cnt <= '0;
                        r_locked    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign bus.period_out    = r_period_out;
    assign bus.width_out     = r_width_out;
    assign bus.measure_valid = r_measure_valid;
    assign bus.locked        = r_locked;
    assign bus.position_out  = r_cnt;
    assign bus.timeout_err   = r_timeout_err;
endmodule
